wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone B4 classic arbiter for the picorv32 SoC.
- Shares the SoC slave bus (bootrom / SRAM0 / UART decode) between the CPU master (m0) and a second master (m1), such as the UART loader or debug DMA.
- Round-robin grant; the grant is held for a whole bus cycle (CYC high).
- Optional watchdog terminates hung slave accesses with ERR.

---
 rtl/wb_arbiter_2m.sv | 128 ++++++++++++
 tb/tb_wb_arbiter_2m.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B4 classic arbiter, round-robin, grant held for a whole CYC.
// Define WB_ARB_TIMEOUT_EN to build the stalled-slave watchdog (forced ERR after TIMEOUT_CYCLES).
module wb_arbiter_2m #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t r_state, w_next;
  logic   r_last, w_last_nxt;   // index of the most recently granted master
  logic   w_stb_raw, w_timeout;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = r_last ? G0 : G1;
        else if (m0_cyc_i)        w_next = G0;
        else if (m1_cyc_i)        w_next = G1;
      end
      G0: if (!m0_cyc_i) w_next = m1_cyc_i ? G1 : IDLE;
      G1: if (!m1_cyc_i) w_next = m0_cyc_i ? G0 : IDLE;
      default: w_next = IDLE;
    endcase
    if (w_next == G0) w_last_nxt = 1'b0;
    if (w_next == G1) w_last_nxt = 1'b1;
  end

  // Slave-side mux driven from the registered grant only
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    w_stb_raw = 1'b0;
    if (r_state == G0) begin
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      s_sel_o   = m0_sel_i;
      s_we_o    = m0_we_i;
      s_cyc_o   = m0_cyc_i;
      w_stb_raw = m0_stb_i;
    end else if (r_state == G1) begin
      s_adr_o   = m1_adr_i;
      s_dat_o   = m1_dat_i;
      s_sel_o   = m1_sel_i;
      s_we_o    = m1_we_i;
      s_cyc_o   = m1_cyc_i;
      w_stb_raw = m1_stb_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        w_stall;

  // Stall is judged on the unmasked strobe so the forced-ERR cycle does not feed back
  assign w_stall   = s_cyc_o & w_stb_raw & ~s_ack_i & ~s_err_i;
  assign w_timeout = w_stall && (r_wdog == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)                                    r_wdog <= '0;
    else if (!w_stall || w_timeout || w_next != r_state) r_wdog <= '0;
    else                                                r_wdog <= r_wdog + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign s_stb_o  = w_stb_raw & ~w_timeout;
  assign gnt_o    = {r_state == G1, r_state == G0};
  assign m0_ack_o = (r_state == G0) & s_ack_i;
  assign m1_ack_o = (r_state == G1) & s_ack_i;
  assign m0_err_o = (r_state == G0) & (s_err_i | w_timeout);
  assign m1_err_o = (r_state == G1) & (s_err_i | w_timeout);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: per-cycle vector table plus burst, async-reset and watchdog sequences.
module tb_wb_arbiter_2m;
  localparam int AW = 32, DW = 32, SW = DW / 8, TO = 8;
  localparam logic [AW-1:0] M0_ADR = 32'h0000_1000, M1_ADR = 32'h0000_0100;
  localparam logic [DW-1:0] M0_DAT = 32'hDEAD_BEEF, M1_DAT = 32'h1122_3344;
  localparam logic [SW-1:0] M0_SEL = 4'hF, M1_SEL = 4'h3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat, m1_dat, m0_rd, m1_rd, s_wd, s_rd;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]    gnt;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_sel_o(s_sel), .s_we_o(s_we), .s_cyc_o(s_cyc),
    .s_stb_o(s_stb), .s_dat_i(s_rd), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic m0c, m0s, m0w, m1c, m1s, m1w, ack, err;
    logic [1:0] gnt;
    logic scyc, sstb, swe, a0, e0, a1, e1;
  } vec_t;

  vec_t v[21];

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // m0c m0s m0w m1c m1s m1w ack err | gnt scyc sstb swe a0 e0 a1 e1
    v[0]  = '{0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0,0};  // idle after reset
    v[1]  = '{1,1,1,1,1,0,0,0, 2'b00, 0,0,0,0,0,0,0};  // simultaneous request
    v[2]  = '{1,1,1,1,1,0,1,0, 2'b01, 1,1,1,1,0,0,0};  // m0 wins first contest
    v[3]  = '{0,0,0,1,1,0,0,0, 2'b01, 0,0,0,0,0,0,0};  // m0 drops cyc
    v[4]  = '{0,0,0,1,1,0,1,0, 2'b10, 1,1,0,0,0,1,0};  // direct hand-off
    v[5]  = '{0,0,0,0,0,0,0,0, 2'b10, 0,0,0,0,0,0,0};
    v[6]  = '{0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0,0};
    v[7]  = '{1,1,0,1,1,0,0,0, 2'b00, 0,0,0,0,0,0,0};  // contest after m1
    v[8]  = '{1,1,0,1,1,0,1,0, 2'b01, 1,1,0,1,0,0,0};  // m0 wins
    v[9]  = '{0,0,0,0,0,0,0,0, 2'b01, 0,0,0,0,0,0,0};
    v[10] = '{0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0,0};
    v[11] = '{1,1,1,0,0,0,0,0, 2'b00, 0,0,0,0,0,0,0};  // m0 write, 1-wait slave
    v[12] = '{1,1,1,0,0,0,0,0, 2'b01, 1,1,1,0,0,0,0};
    v[13] = '{1,1,1,0,0,0,1,0, 2'b01, 1,1,1,1,0,0,0};
    v[14] = '{0,0,0,0,0,0,0,0, 2'b01, 0,0,0,0,0,0,0};
    v[15] = '{0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0,0};
    v[16] = '{0,0,0,1,1,0,0,0, 2'b00, 0,0,0,0,0,0,0};  // m1 read
    v[17] = '{0,0,0,1,1,0,0,1, 2'b10, 1,1,0,0,0,0,1};  // slave err
    v[18] = '{0,0,0,1,1,0,1,1, 2'b10, 1,1,0,0,0,1,1};  // ack+err both forwarded
    v[19] = '{0,0,0,0,0,0,0,0, 2'b10, 0,0,0,0,0,0,0};
    v[20] = '{0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0,0};

    m0_adr = M0_ADR; m0_dat = M0_DAT; m0_sel = M0_SEL;
    m1_adr = M1_ADR; m1_dat = M1_DAT; m1_sel = M1_SEL;
    m0_we = 0; m0_cyc = 0; m0_stb = 0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    s_rd = '0; s_ack = 0; s_err = 0;

    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_scyc", 32'(s_cyc), 32'd0);
    chk("rst_sstb_swe", 32'({s_stb, s_we}), 32'd0);
    chk("rst_ack_err", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [SW-1:0] es;
      m0_cyc = v[i].m0c; m0_stb = v[i].m0s; m0_we = v[i].m0w;
      m1_cyc = v[i].m1c; m1_stb = v[i].m1s; m1_we = v[i].m1w;
      s_ack = v[i].ack; s_err = v[i].err; s_rd = 32'hA000_0000 | 32'(i);
      ea = v[i].gnt == 2'b01 ? M0_ADR : v[i].gnt == 2'b10 ? M1_ADR : '0;
      ed = v[i].gnt == 2'b01 ? M0_DAT : v[i].gnt == 2'b10 ? M1_DAT : '0;
      es = v[i].gnt == 2'b01 ? M0_SEL : v[i].gnt == 2'b10 ? M1_SEL : '0;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
      chk($sformatf("v%0d_cyc_stb_we", i), 32'({s_cyc, s_stb, s_we}),
          32'({v[i].scyc, v[i].sstb, v[i].swe}));
      chk($sformatf("v%0d_ack_err", i), 32'({m0_ack, m0_err, m1_ack, m1_err}),
          32'({v[i].a0, v[i].e0, v[i].a1, v[i].e1}));
      chk($sformatf("v%0d_adr", i), s_adr, ea);
      chk($sformatf("v%0d_wdat", i), s_wd, ed);
      chk($sformatf("v%0d_sel", i), 32'(s_sel), 32'(es));
      chk($sformatf("v%0d_rdat", i), m0_rd ^ m1_rd, 32'd0);
      chk($sformatf("v%0d_m1_rdat", i), m1_rd, 32'hA000_0000 | 32'(i));
      tick();
    end

    // m1 4-beat locked read burst while m0 waits
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h100; s_ack = 0; s_err = 0;
    @(negedge clk); chk("burst_pre_gnt", 32'(gnt), 32'd0);
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0;
    for (int k = 0; k < 4; k++) begin
      m1_adr = 32'h100 + 32'(4 * k); s_ack = 1; s_rd = 32'hC0DE_0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("burst%0d_gnt", k), 32'(gnt), 32'b10);
      chk($sformatf("burst%0d_adr", k), s_adr, 32'h100 + 32'(4 * k));
      chk($sformatf("burst%0d_acks", k), 32'({m0_ack, m1_ack}), 32'b01);
      chk($sformatf("burst%0d_rdat", k), m1_rd, 32'hC0DE_0000 + 32'(k));
      tick();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk); chk("burst_release_gnt", 32'(gnt), 32'b10);
    chk("burst_release_m0ack", 32'(m0_ack), 32'd0);
    tick();
    s_ack = 1;
    @(negedge clk); chk("burst_m0_gnt", 32'(gnt), 32'b01);
    chk("burst_m0_adr", s_adr, M0_ADR);
    chk("burst_m0_ack", 32'(m0_ack), 32'd1);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0; m1_adr = M1_ADR;
    tick(); tick();

    // Asynchronous reset mid-transfer; m0 must win the first contest after release
    m1_cyc = 1; m1_stb = 1;
    tick();
    @(negedge clk); chk("arst_pre_gnt", 32'(gnt), 32'b10);
    #2 rst_n = 0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_cyc_stb", 32'({s_cyc, s_stb}), 32'd0);
    m0_cyc = 1; m0_stb = 1;
    tick();
    @(negedge clk); rst_n = 1;
    tick();
    @(negedge clk); chk("arst_first_gnt", 32'(gnt), 32'b01);
    tick();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // Slave never answers
    m0_cyc = 1; m0_stb = 1; s_ack = 0; s_err = 0;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      chk($sformatf("wdog%0d_err", n), 32'(m0_err), 32'(n == TO));
      chk($sformatf("wdog%0d_stb", n), 32'(s_stb), 32'(n != TO));
      tick();
    end
    @(negedge clk);
    chk("wdog_after_err", 32'(m0_err), 32'd0);
    chk("wdog_after_gnt", 32'(gnt), 32'b01);
`else
    begin
      int errs_seen = 0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (m0_err) errs_seen++;
        tick();
      end
      @(negedge clk);
      chk("stall_no_err", 32'(errs_seen), 32'd0);
      chk("stall_gnt", 32'(gnt), 32'b01);
      chk("stall_stb", 32'(s_stb), 32'd1);
    end
`endif
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
